// File: rtl/mavg_filter_pkg.sv
// Shared types and width helpers for the multi-channel moving-average filter.
package mavg_filter_pkg;

    // Wide enough for any MAX_REJECT up to 256.
    localparam int REJ_W = 8;

    typedef struct packed {
        logic             primed;
        logic [REJ_W-1:0] rej_cnt;
    } ch_ctrl_t;

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    function automatic int sum_w(input int data_w, input int depth_log2);
        return data_w + depth_log2;
    endfunction

endpackage

// File: rtl/mavg_outlier_gate.sv
// Outlier gate: |sample - last accepted| against threshold, with a forced accept
// once a channel has rejected MAX_REJECT-1 samples in a row.
module mavg_outlier_gate
    import mavg_filter_pkg::*;
#(
    parameter int DATA_W     = 19,
    parameter int MAX_REJECT = 4
) (
    input  logic              primed,
    input  logic [REJ_W-1:0]  rej_cnt,
    input  logic [DATA_W-1:0] sample,
    input  logic [DATA_W-1:0] last_acc,
    input  logic [DATA_W-1:0] dev_thresh,
    output logic              accept
);
    logic [DATA_W-1:0] dev;
    logic              in_range;
    logic              forced;

    // Subtract the smaller from the larger so the distance never wraps.
    always_comb begin
        dev = (sample >= last_acc) ? (sample - last_acc) : (last_acc - sample);
    end

    assign in_range = (dev <= dev_thresh);
    assign forced   = (rej_cnt == REJ_W'(MAX_REJECT - 1));
    assign accept   = !primed || in_range || forced;

endmodule

// File: rtl/mavg_filter_mc.sv
// Time-multiplexed moving-average filter with outlier rejection, NUM_CH channels.
// Optional FILTER_PRIME_EN: first accepted sample fills the whole window.
module mavg_filter_mc
    import mavg_filter_pkg::*;
#(
    parameter  int DATA_W     = 19,
    parameter  int DEPTH_LOG2 = 3,
    parameter  int NUM_CH     = 4,
    parameter  int MAX_REJECT = 4,
    localparam int CH_W       = ch_w(NUM_CH),
    localparam int SUM_W      = sum_w(DATA_W, DEPTH_LOG2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] dev_thresh,
    output logic              out_valid,
    output logic [CH_W-1:0]   out_ch,
    output logic [DATA_W-1:0] out_data,
    output logic              out_rejected
);
    localparam int DEPTH  = 2**DEPTH_LOG2;
    localparam int STAGES = 2;

    logic [NUM_CH-1:0][DEPTH-1:0][DATA_W-1:0] buf_q;
    logic [NUM_CH-1:0][SUM_W-1:0]             sum_q;
    logic [NUM_CH-1:0][DATA_W-1:0]            last_q;
    logic [NUM_CH-1:0][DEPTH_LOG2-1:0]        wptr_q;
    ch_ctrl_t [NUM_CH-1:0]                    ctrl_q;

    logic                  ch_ok, in_ok, accept, fill_all;
    ch_ctrl_t              cur_ctrl;
    logic [SUM_W-1:0]      cur_sum, new_sum, upd_sum;
    logic [DATA_W-1:0]     cur_last, old_val;
    logic [DEPTH_LOG2-1:0] cur_ptr;

    if (2**CH_W > NUM_CH) begin : g_chk
        assign ch_ok = ({1'b0, in_ch} < (CH_W+1)'(NUM_CH));
    end else begin : g_nochk
        assign ch_ok = 1'b1;
    end

    assign in_ok = in_valid && ch_ok && !clr;

    // Stage 1 read side: the selected channel's state, fully updated by any previous sample.
    always_comb begin
        cur_ctrl = ctrl_q[in_ch];
        cur_sum  = sum_q[in_ch];
        cur_last = last_q[in_ch];
        cur_ptr  = wptr_q[in_ch];
        old_val  = buf_q[in_ch][cur_ptr];
    end

`ifdef FILTER_PRIME_EN
    assign fill_all = !cur_ctrl.primed;
`else
    assign fill_all = 1'b0;
`endif

    mavg_outlier_gate #(
        .DATA_W     (DATA_W),
        .MAX_REJECT (MAX_REJECT)
    ) u_gate (
        .primed     (cur_ctrl.primed),
        .rej_cnt    (cur_ctrl.rej_cnt),
        .sample     (in_data),
        .last_acc   (cur_last),
        .dev_thresh (dev_thresh),
        .accept     (accept)
    );

    // Running sum: add newest, drop the entry being overwritten.
    always_comb begin
        if (fill_all)
            new_sum = SUM_W'(in_data) << DEPTH_LOG2;
        else
            new_sum = cur_sum + SUM_W'(in_data) - SUM_W'(old_val);
        upd_sum = accept ? new_sum : cur_sum;
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                         hit;
        logic [DEPTH-1:0][DATA_W-1:0] buf_r;
        logic [SUM_W-1:0]             sum_r;
        logic [DATA_W-1:0]            last_r;
        logic [DEPTH_LOG2-1:0]        wptr_r;
        ch_ctrl_t                     ctrl_r;

        assign hit = in_ok && (in_ch == CH_W'(c));

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                buf_r  <= '0;
                sum_r  <= '0;
                last_r <= '0;
                wptr_r <= '0;
                ctrl_r <= '0;
            end else if (hit && accept) begin
                for (int e = 0; e < DEPTH; e++)
                    if (fill_all || (cur_ptr == DEPTH_LOG2'(e)))
                        buf_r[e] <= in_data;
                sum_r          <= new_sum;
                last_r         <= in_data;
                wptr_r         <= cur_ptr + DEPTH_LOG2'(1);
                ctrl_r.primed  <= 1'b1;
                ctrl_r.rej_cnt <= '0;
            end else if (hit && (ctrl_r.rej_cnt != '1)) begin
                ctrl_r.rej_cnt <= ctrl_r.rej_cnt + REJ_W'(1);
            end
        end

        assign buf_q[c]  = buf_r;
        assign sum_q[c]  = sum_r;
        assign last_q[c] = last_r;
        assign wptr_q[c] = wptr_r;
        assign ctrl_q[c] = ctrl_r;
    end

    logic [STAGES:1]  vld_pipe;
    logic [CH_W-1:0]  s1_ch;
    logic [SUM_W-1:0] s1_sum;
    logic             s1_rej;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_pipe     <= '0;
            s1_ch        <= '0;
            s1_sum       <= '0;
            s1_rej       <= 1'b0;
            out_ch       <= '0;
            out_data     <= '0;
            out_rejected <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_ok};
            if (in_ok) begin
                s1_ch  <= in_ch;
                s1_sum <= upd_sum;
                s1_rej <= !accept;
            end
            if (vld_pipe[1]) begin
                out_ch       <= s1_ch;
                out_data     <= DATA_W'(s1_sum >> DEPTH_LOG2);
                out_rejected <= s1_rej;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];

endmodule

// File: tb/tb_mavg_filter_mc.sv
// Bench for mavg_filter_mc: directed scenarios then random traffic against a window-queue model.
module tb_mavg_filter_mc;
    localparam int DATA_W     = 19;
    localparam int DEPTH_LOG2 = 3;
    localparam int NUM_CH     = 4;
    localparam int MAX_REJECT = 4;
    localparam int CH_W       = 2;
    localparam int DEPTH      = 8;
    localparam int DMAX       = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clr = 1'b0;
    logic              in_valid = 1'b0;
    logic [CH_W-1:0]   in_ch = '0;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] dev_thresh = '0;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;
    logic              out_rejected;

    int total = 0;
    int bad   = 0;
    int thr   = 100;

    always #5 clk = ~clk;

    mavg_filter_mc #(
        .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2), .NUM_CH(NUM_CH), .MAX_REJECT(MAX_REJECT)
    ) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ch(in_ch),
        .in_data(in_data), .dev_thresh(dev_thresh), .out_valid(out_valid),
        .out_ch(out_ch), .out_data(out_data), .out_rejected(out_rejected)
    );

    typedef struct {
        bit v;
        int ch;
        int data;
        bit rej;
    } exp_t;

    // Model: each channel's window is the list of its most recent accepted samples.
    int win [NUM_CH][$];
    int last_acc [NUM_CH];
    int rej_run [NUM_CH];
    bit primed [NUM_CH];
    exp_t e1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            win[c].delete();
            last_acc[c] = 0;
            rej_run[c]  = 0;
            primed[c]   = 0;
        end
    endtask

    function automatic exp_t model_step(input int ch, input int d, input int t);
        exp_t r;
        int dev, s;
        bit acc, fill;
        dev  = (d > last_acc[ch]) ? d - last_acc[ch] : last_acc[ch] - d;
        acc  = !primed[ch] || (dev <= t) || (rej_run[ch] == MAX_REJECT - 1);
        fill = 0;
`ifdef FILTER_PRIME_EN
        fill = !primed[ch];
`endif
        if (acc) begin
            if (fill) begin
                repeat (DEPTH) win[ch].push_back(d);
            end else begin
                win[ch].push_back(d);
                if (win[ch].size() > DEPTH) void'(win[ch].pop_front());
            end
            last_acc[ch] = d;
            rej_run[ch]  = 0;
            primed[ch]   = 1;
        end else begin
            rej_run[ch]++;
        end
        s = 0;
        foreach (win[ch][i]) s += win[ch][i];
        r.v    = 1;
        r.ch   = ch;
        r.data = s / DEPTH;
        r.rej  = !acc;
        return r;
    endfunction

    // One clock: drive inputs, advance, then check what the pipeline should show now.
    task automatic cycle(input bit v, input int ch, input int d, input bit c_clr, input bit c_rst,
                         input string tag);
        exp_t cur;
        cur.v = 0; cur.ch = 0; cur.data = 0; cur.rej = 0;
        rst = c_rst; clr = c_clr; in_valid = v;
        in_ch = CH_W'(ch); in_data = DATA_W'(d); dev_thresh = DATA_W'(thr);
        if (c_rst || c_clr) model_reset();
        else if (v) cur = model_step(ch, d, thr);
        @(posedge clk); #1;
        if (c_rst || c_clr) begin
            chk({tag, ":flush_vld"}, 32'(out_valid), 0);
            if (c_rst) begin
                chk({tag, ":rst_data"}, 32'(out_data), 0);
                chk({tag, ":rst_ch"}, 32'(out_ch), 0);
                chk({tag, ":rst_rej"}, 32'(out_rejected), 0);
            end
            e1.v = 0;
        end else begin
            chk({tag, ":vld"}, 32'(out_valid), 32'(e1.v));
            if (e1.v) begin
                chk({tag, ":ch"}, 32'(out_ch), 32'(e1.ch));
                chk({tag, ":data"}, 32'(out_data), 32'(e1.data));
                chk({tag, ":rej"}, 32'(out_rejected), 32'(e1.rej));
            end
            e1 = cur;
        end
        rst = 0; clr = 0; in_valid = 0;
    endtask

    task automatic send(input int ch, input int d, input string tag);
        cycle(1, ch, d, 0, 0, tag);
    endtask

    task automatic idle(input string tag);
        cycle(0, 0, 0, 0, 0, tag);
    endtask

    initial begin
        int r, ch, d, delta;
        e1.v = 0; e1.ch = 0; e1.data = 0; e1.rej = 0;
        model_reset();

        cycle(0, 0, 0, 0, 1, "reset0");
        cycle(0, 0, 0, 0, 1, "reset1");
        idle("post_reset");

        // First sample on ch0, then a full window of the same value.
        send(0, 800, "first");
        idle("first_out");
        for (int i = 0; i < 7; i++) send(0, 800, "fill");
        idle("fill_drain");

        // Outlier run: three rejections, fourth forced in.
        for (int i = 0; i < 4; i++) send(0, 2000, "outlier");
        idle("outlier_drain");

        // Prime ch1, then interleave two channels every cycle.
        for (int i = 0; i < 8; i++) send(1, 300, "ch1_fill");
        for (int i = 0; i < 6; i++) begin
            send(0, 2000, "ilv0");
            send(1, 300, "ilv1");
        end
        idle("ilv_drain");

        // Soft clear with a colliding sample, then restart of ch0.
        send(2, 1234, "pre_clr");
        cycle(1, 0, 500, 1, 0, "clr");
        idle("post_clr");
        send(0, 500, "after_clr");
        idle("after_clr_out");

        // Reset with two samples in flight.
        send(3, 4000, "fly0");
        send(3, 4050, "fly1");
        cycle(0, 0, 0, 0, 1, "rst_fly");
        idle("rst_fly_next");
        idle("rst_fly_next2");
        send(3, 4000, "after_rst");
        idle("after_rst_out");

        // Random traffic near each channel's last accepted value, with rare far jumps and clears.
        for (int n = 0; n < 600; n++) begin
            r   = int'($urandom_range(0, 99));
            thr = int'($urandom_range(40, 250));
            ch  = int'($urandom_range(0, NUM_CH - 1));
            if (r < 2) begin
                cycle(($urandom_range(0, 1) == 1), ch, 100, 1, 0, "rnd_clr");
            end else if (r < 12) begin
                idle("rnd_idle");
            end else begin
                delta = int'($urandom_range(0, 350));
                d = ($urandom_range(0, 1) == 1) ? last_acc[ch] + delta : last_acc[ch] - delta;
                if (r < 17) d = int'($urandom_range(0, DMAX));
                if (d < 0) d = 0;
                if (d > DMAX) d = DMAX;
                send(ch, d, "rnd");
            end
        end
        idle("final0");
        idle("final1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
